// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Multicycle fetch stage. Holds the PC. For each fetch_req it runs one
//   req/ready read of instruction memory, then hands the word to the
//   instruction register as ir_data with a one-cycle ir_w strobe, and
//   advances the PC by 4. It also handles redirects, a misaligned PC and a
//   memory that never answers.
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   fetch_req             start a fetch at the current PC (acted on in IDLE only)
//   pc_load, pc_target    redirect strobe and its target
//   imem_addr, imem_rd    registered memory address and read request
//   imem_ready, imem_rdata  memory handshake and returned word
//   ir_data, ir_w         fetched word and one-cycle write strobe to the IR
//   pc, pc_plus4          current PC and PC+4 (mod 2**32)
//   busy                  high while waiting on memory
//   misalign_err, timeout_err  sticky error flags, cleared by pc_load in ERR
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_data,
    output logic        ir_w,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            addr_q, addr_d;
    logic                   rd_q, rd_d;
    logic [31:0]            ir_data_q, ir_data_d;
    logic                   ir_w_q, ir_w_d;
    logic                   mis_q, mis_d;
    logic                   to_q, to_d;
    logic                   flush_q, flush_d;
    logic [31:0]            tgt_q, tgt_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= 32'h0;
            rd_q      <= 1'b0;
            ir_data_q <= 32'h0;
            ir_w_q    <= 1'b0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            flush_q   <= 1'b0;
            tgt_q     <= 32'h0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            ir_data_q <= ir_data_d;
            ir_w_q    <= ir_w_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            flush_q   <= flush_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        ir_data_d = ir_data_q;
        ir_w_d    = 1'b0;
        mis_d     = mis_q;
        to_d      = to_q;
        flush_d   = flush_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // A redirect wins over a fetch issued in the same cycle.
                if (pc_load) begin
                    pc_d = pc_target;
                end else if (fetch_req && (pc_q[1:0] != 2'b00)) begin
                    mis_d   = 1'b1;
                    state_d = S_ERR;
                end else if (fetch_req) begin
                    addr_d  = pc_q;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ready) begin
                    rd_d    = 1'b0;
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                    // A redirect arriving with the data still drops the word.
                    if (pc_load) begin
                        pc_d = pc_target;
                    end else if (flush_q) begin
                        pc_d = tgt_q;
                    end else begin
                        ir_data_d = imem_rdata;
                        ir_w_d    = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    // Timeout takes precedence over a redirect in the same cycle.
                    if (cnt_inc == '1) begin
                        rd_d    = 1'b0;
                        to_d    = 1'b1;
                        flush_d = 1'b0;
                        state_d = S_ERR;
                    end else if (pc_load) begin
                        tgt_d   = pc_target;
                        flush_d = 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (pc_load) begin
                    mis_d   = 1'b0;
                    to_d    = 1'b0;
                    pc_d    = pc_target;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr    = addr_q;
    assign imem_rd      = rd_q;
    assign ir_data      = ir_data_q;
    assign ir_w         = ir_w_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign busy         = (state_q == S_WAIT);
    assign misalign_err = mis_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TW     = 4;
    localparam int          TLIM   = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ir_data;
    logic        ir_w;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        misalign_err;
    logic        timeout_err;

    int total = 0;
    int bad = 0;

    instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_target(pc_target), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir_data(ir_data),
        .ir_w(ir_w), .pc(pc), .pc_plus4(pc_plus4), .busy(busy),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog");
    end

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: a fetch is outstanding or not, an error is parked or
    // not, and a redirect may be pending behind the outstanding fetch.
    logic [31:0] m_pc, m_addr, m_ir, m_tgt;
    bit          m_busy, m_err, m_irw, m_mis, m_to, m_redir;
    int          m_waited;

    task automatic model_reset();
        m_pc = RST_PC; m_addr = 0; m_ir = 0; m_tgt = 0;
        m_busy = 0; m_err = 0; m_irw = 0; m_mis = 0; m_to = 0; m_redir = 0;
        m_waited = 0;
    endtask

    task automatic model_edge(input bit f, input bit l, input logic [31:0] t, input bit r);
        m_irw = 0;
        if (m_err) begin
            if (l) begin m_err = 0; m_mis = 0; m_to = 0; m_pc = t; end
        end else if (!m_busy) begin
            if (l) m_pc = t;
            else if (f && (m_pc % 4 != 0)) begin m_mis = 1; m_err = 1; end
            else if (f) begin m_addr = m_pc; m_busy = 1; m_waited = 0; end
        end else if (r) begin
            if (l) m_pc = t;
            else if (m_redir) m_pc = m_tgt;
            else begin m_ir = mem(m_addr); m_irw = 1; m_pc = m_pc + 32'd4; end
            m_redir = 0; m_busy = 0;
        end else begin
            m_waited++;
            if (m_waited == TLIM) begin m_to = 1; m_err = 1; m_busy = 0; m_redir = 0; end
            else if (l) begin m_tgt = t; m_redir = 1; end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%h req=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_rd", {31'b0, imem_rd}, {31'b0, m_busy});
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("ir_w", {31'b0, ir_w}, {31'b0, m_irw});
        chk("ir_data", ir_data, m_ir);
        chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("timeout", {31'b0, timeout_err}, {31'b0, m_to});
        if (m_busy) chk("imem_addr", imem_addr, m_addr);
    endtask

    // Called at a negedge: drive, clock once, sample at the next negedge.
    task automatic step(input bit f, input bit l, input logic [31:0] t, input bit r);
        fetch_req = f; pc_load = l; pc_target = t; imem_ready = r;
        imem_rdata = mem(imem_addr);
        model_edge(f, l, t, r);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit          f;
        bit          l;
        logic [31:0] t;
        bit          r;
        logic [31:0] e_pc;
        bit          e_irw;
        bit          e_rd;
        logic [31:0] e_ir;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] a0;
        logic [31:0] rv;
        int          irw_cnt;

        // Reset state
        model_reset();
        #1;
        check_model();
        chk("rst_addr", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait fetches from address 0, then a redirect that beats a fetch.
        vecs.push_back('{1, 0, 0,     0, 32'h00, 0, 1, 32'h0});
        vecs.push_back('{0, 0, 0,     1, 32'h04, 1, 0, mem(32'h0)});
        vecs.push_back('{1, 0, 0,     0, 32'h04, 0, 1, mem(32'h0)});
        vecs.push_back('{0, 0, 0,     1, 32'h08, 1, 0, mem(32'h4)});
        vecs.push_back('{1, 0, 0,     0, 32'h08, 0, 1, mem(32'h4)});
        vecs.push_back('{0, 0, 0,     1, 32'h0C, 1, 0, mem(32'h8)});
        vecs.push_back('{0, 0, 0,     0, 32'h0C, 0, 0, mem(32'h8)});
        vecs.push_back('{1, 1, 32'h20, 0, 32'h20, 0, 0, mem(32'h8)});
        vecs.push_back('{1, 0, 0,     1, 32'h20, 0, 1, mem(32'h8)});
        vecs.push_back('{0, 0, 0,     1, 32'h24, 1, 0, mem(32'h20)});
        foreach (vecs[i]) begin
            step(vecs[i].f, vecs[i].l, vecs[i].t, vecs[i].r);
            chk($sformatf("tbl%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("tbl%0d_irw", i), {31'b0, ir_w}, {31'b0, vecs[i].e_irw});
            chk($sformatf("tbl%0d_rd", i), {31'b0, imem_rd}, {31'b0, vecs[i].e_rd});
            chk($sformatf("tbl%0d_ir", i), ir_data, vecs[i].e_ir);
        end

        // Memory answers on the 5th request cycle.
        step(1, 0, 0, 0);
        a0 = imem_addr;
        chk("slow_addr", a0, 32'h24);
        irw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("slow_rd", {31'b0, imem_rd}, 32'h1);
            chk("slow_addr_hold", imem_addr, 32'h24);
            irw_cnt += int'(ir_w);
        end
        step(0, 0, 0, 1);
        irw_cnt += int'(ir_w);
        step(0, 0, 0, 0);
        irw_cnt += int'(ir_w);
        chk("slow_irw_count", irw_cnt, 1);
        chk("slow_pc", pc, 32'h28);

        // Redirect while waiting drops the pending word.
        step(1, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("flush_irw", {31'b0, ir_w}, 32'h0);
        chk("flush_pc", pc, 32'h100);
        step(1, 0, 0, 0);
        chk("flush_next_addr", imem_addr, 32'h100);
        step(0, 1, 32'h200, 1);
        chk("flush_same_cycle_irw", {31'b0, ir_w}, 32'h0);
        chk("flush_same_cycle_pc", pc, 32'h200);

        // Misaligned PC.
        step(0, 1, 32'h102, 0);
        step(1, 0, 0, 0);
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_rd", {31'b0, imem_rd}, 32'h0);
        step(1, 0, 0, 0);
        chk("mis_err_fetch_ignored", {31'b0, imem_rd}, 32'h0);
        step(0, 1, 32'h104, 0);
        chk("mis_clear", {31'b0, misalign_err}, 32'h0);
        chk("mis_clear_pc", pc, 32'h104);

        // Memory never answers.
        step(1, 0, 0, 0);
        for (int i = 1; i < TLIM; i++) step(0, 0, 0, 0);
        chk("to_before", {31'b0, timeout_err, imem_rd}, 32'h1);
        step(0, 0, 0, 0);
        chk("to_err", {31'b0, timeout_err}, 32'h1);
        chk("to_rd", {31'b0, imem_rd}, 32'h0);
        step(0, 1, 32'h40, 0);
        chk("to_clear", {31'b0, timeout_err}, 32'h0);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFFC, 0);
        chk("wrap_pc4", pc_plus4, 32'h0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("wrap_irw", {31'b0, ir_w}, 32'h1);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_err", {30'b0, misalign_err, timeout_err}, 32'h0);

        // Reset during WAIT takes effect without a clock edge.
        step(0, 1, 32'h40, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstw_rd", {31'b0, imem_rd}, 32'h0);
        chk("rstw_pc", pc, RST_PC);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rv = $urandom();
            if ($urandom_range(0, 9) != 0) rv = rv & 32'hFFFF_FFFC;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, rv,
                 $urandom_range(0, 9) < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
